// File: rtl/tracer_rx_pkg.sv
// Shared encodings and types for the tracer RX channel.
package tracer_rx_pkg;

  localparam logic [1:0] DS_BYTE = 2'b00;
  localparam logic [1:0] DS_HALF = 2'b01;

  typedef enum logic {IDLE, RUN} rx_state_t;

  typedef struct packed {
    logic [1:0]  datasize;
    logic [15:0] data;
  } rx_beat_t;

endpackage

// File: rtl/tracer_rx_fifo.sv
// Small synchronous beat FIFO with flush; pointers carry an extra wrap bit.
module tracer_rx_fifo import tracer_rx_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  logic     flush,
  input  rx_beat_t din,
  output rx_beat_t dout,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  rx_beat_t       mem [DEPTH];
  logic [PW:0]    wptr;
  logic [PW:0]    rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign dout  = mem[rptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + (PW+1)'(1);
      if (pop && !empty) rptr <= rptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/tracer_rx_channel.sv
// uDMA-style RX channel: buffers tracer beats and writes them to L2 with
// address/length tracking, continuous reload and one queued transfer.
module tracer_rx_channel import tracer_rx_pkg::*; #(
  parameter int unsigned L2_AWIDTH_NOAL = 12,
  parameter int unsigned TRANS_SIZE     = 16,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_rx_size_i,
  input  logic                      cfg_rx_continuous_i,
  input  logic                      cfg_rx_en_i,
  input  logic                      cfg_rx_clr_i,
  output logic                      cfg_rx_en_o,
  output logic                      cfg_rx_pending_o,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_o,
  output logic [TRANS_SIZE-1:0]     cfg_rx_bytes_left_o,
  input  logic [1:0]                data_rx_datasize_i,
  input  logic [15:0]               data_rx_data_i,
  input  logic                      data_rx_valid_i,
  output logic                      data_rx_ready_o,
  output logic                      l2_req_o,
  input  logic                      l2_gnt_i,
  output logic [L2_AWIDTH_NOAL-1:0] l2_addr_o,
  output logic [31:0]               l2_wdata_o,
  output logic [3:0]                l2_be_o,
  output logic                      end_of_transfer_o
);

  rx_state_t                 state, state_nxt;
  logic [L2_AWIDTH_NOAL-1:0] curr_addr, pend_addr;
  logic [TRANS_SIZE-1:0]     bytes_left, pend_size, step;
  logic                      pending, clr_hold;
  rx_beat_t                  head;
  logic                      full, empty, half;
  logic                      req, gnt_hit, clr_eff, done, en_ok;
  logic                      load_cfg, load_pend, capture;
  logic [3:0]                be;

  tracer_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (data_rx_valid_i && data_rx_ready_o),
    .pop   (gnt_hit),
    .flush (clr_eff),
    .din   ('{datasize: data_rx_datasize_i, data: data_rx_data_i}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign half    = head.datasize[1] || (head.datasize == DS_HALF);
  assign step    = half ? TRANS_SIZE'(2) : TRANS_SIZE'(1);
  assign req     = (state == RUN) && !empty && (bytes_left != '0);
  assign gnt_hit = req && l2_gnt_i;
  // A clear arriving while a request waits for grant is held until that write lands.
  assign clr_eff = (cfg_rx_clr_i || clr_hold) && !(req && !l2_gnt_i);
  assign done    = (state == RUN) && (bytes_left == '0) && !clr_eff;
  assign en_ok   = cfg_rx_en_i && !cfg_rx_clr_i && !clr_hold;

  // On completion with nothing queued, a same-cycle start is taken directly.
  assign load_cfg  = ((state == IDLE) && en_ok) ||
                     (done && (cfg_rx_continuous_i || (!pending && en_ok)));
  assign load_pend = done && !cfg_rx_continuous_i && pending;
  assign capture   = (state == RUN) && en_ok &&
                     !(done && !cfg_rx_continuous_i && !pending);

  always_comb begin
    be = '0;
    if (!half)               be = 4'b0001 << curr_addr[1:0];
    else if (bytes_left == TRANS_SIZE'(1)) be = curr_addr[1] ? 4'b0100 : 4'b0001;
    else                     be = curr_addr[1] ? 4'b1100 : 4'b0011;
  end

  always_comb begin
    state_nxt = state;
    if (clr_eff) begin
      state_nxt = IDLE;
    end else if (state == IDLE) begin
      if (en_ok) state_nxt = RUN;
    end else if (done && !cfg_rx_continuous_i && !pending && !en_ok) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state             <= IDLE;
      curr_addr         <= '0;
      bytes_left        <= '0;
      pending           <= 1'b0;
      pend_addr         <= '0;
      pend_size         <= '0;
      clr_hold          <= 1'b0;
      end_of_transfer_o <= 1'b0;
    end else begin
      state             <= state_nxt;
      end_of_transfer_o <= done;
      clr_hold          <= (cfg_rx_clr_i || clr_hold) && !clr_eff;
      if (load_cfg) begin
        curr_addr  <= cfg_rx_startaddr_i;
        bytes_left <= cfg_rx_size_i;
      end else if (load_pend) begin
        curr_addr  <= pend_addr;
        bytes_left <= pend_size;
      end else if (gnt_hit) begin
        curr_addr  <= curr_addr + L2_AWIDTH_NOAL'(step);
        bytes_left <= (bytes_left > step) ? bytes_left - step : '0;
      end
      if (clr_eff) begin
        pending <= 1'b0;
      end else if (capture) begin
        pending   <= 1'b1;
        pend_addr <= cfg_rx_startaddr_i;
        pend_size <= cfg_rx_size_i;
      end else if (load_pend) begin
        pending <= 1'b0;
      end
    end
  end

  assign cfg_rx_en_o         = (state == RUN);
  assign cfg_rx_pending_o    = pending;
  assign cfg_rx_curr_addr_o  = curr_addr;
  assign cfg_rx_bytes_left_o = bytes_left;
  assign data_rx_ready_o     = (state == RUN) && !full;
  assign l2_req_o            = req;
  assign l2_addr_o           = curr_addr;
  assign l2_be_o             = req ? be : '0;
  assign l2_wdata_o          = !req ? '0 :
                               half ? {2{head.data}} : {4{head.data[7:0]}};

endmodule

// File: doc/tracer_rx_channel.md
Name: tracer_rx_channel

Overview:
- Receiving end of the tracer data stream: models the uDMA RX channel that the tracer peripheral pushes into.
- Accepts 16-bit beats on a valid/ready handshake and buffers them in a small FIFO.
- Writes each beat to L2 through a req/gnt port, tracking current address and bytes left.
- Exposes the same configuration/status signals the register interface programs and reads back (start, size, continuous, enable, clear, pending).

Parameters:
- L2_AWIDTH_NOAL, 12: L2 byte-address width.
- TRANS_SIZE, 16: width of the transfer-size and bytes-left counters.
- FIFO_DEPTH, 4: beat FIFO entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- cfg_rx_startaddr_i  in  L2_AWIDTH_NOAL  buffer start byte address.
- cfg_rx_size_i  in  TRANS_SIZE  transfer length in bytes.
- cfg_rx_continuous_i  in  1  reload start/size on completion.
- cfg_rx_en_i  in  1  one-cycle start pulse.
- cfg_rx_clr_i  in  1  one-cycle abort/flush pulse.
- cfg_rx_en_o  out  1  channel running.
- cfg_rx_pending_o  out  1  queued transfer waiting.
- cfg_rx_curr_addr_o  out  L2_AWIDTH_NOAL  next write byte address.
- cfg_rx_bytes_left_o  out  TRANS_SIZE  bytes remaining.
- data_rx_datasize_i  in  2  00 byte, 01 halfword, 1x treated as halfword.
- data_rx_data_i  in  16  beat data; a byte beat uses bits [7:0].
- data_rx_valid_i  in  1  beat valid.
- data_rx_ready_o  out  1  beat accepted when valid and ready are both high.
- l2_req_o  out  1  L2 write request.
- l2_gnt_i  in  1  L2 grant.
- l2_addr_o  out  L2_AWIDTH_NOAL  write byte address.
- l2_wdata_o  out  32  write data, beat replicated into both halves/all lanes.
- l2_be_o  out  4  byte enables.
- end_of_transfer_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, pending cleared.
- FSM states: IDLE and RUN.
- IDLE, on cfg_rx_en_i:
  - load curr_addr = startaddr and bytes_left = size;
  - go to RUN next cycle.
- cfg_rx_en_o is 1 exactly when the FSM is in RUN.
- cfg_rx_en_i while in RUN:
  - capture startaddr/size into the pending slot and set pending;
  - a second pulse overwrites the slot.
- Input handshake:
  - data_rx_ready_o = RUN and FIFO not full;
  - beats offered in IDLE are not accepted, and the sender may drop them.
- Latency: a beat accepted in cycle N can drive l2_req_o in cycle N+1 at the earliest. Each FIFO entry stores datasize and data.
- L2 request:
  - In RUN, l2_req_o = FIFO not empty and bytes_left ≠ 0.
  - l2_addr_o, l2_wdata_o and l2_be_o come from curr_addr and the FIFO head.
  - While l2_req_o is high and l2_gnt_i is low, all request outputs hold stable.
  - The FIFO pops on the req&gnt cycle.
- Byte enables:
  - byte beat: l2_be_o = 4'b0001 << curr_addr[1:0];
  - halfword beat: l2_be_o = curr_addr[1] ? 4'b1100 : 4'b0011, and curr_addr[0] is ignored for lane selection.
- Counter update on req&gnt:
  - n = 1 for a byte beat, 2 for a halfword beat;
  - curr_addr += n, wrapping modulo 2^L2_AWIDTH_NOAL;
  - bytes_left -= n, saturating at 0.
  - Halfword beat with bytes_left = 1: only the lower enabled byte is written (be masked to one lane).
- Completion (bytes_left reaches 0): pulse end_of_transfer_o in the following cycle, then:
  - continuous = 1: reload from the current cfg inputs and stay in RUN;
  - else pending = 1: load the pending slot, clear pending, stay in RUN;
  - else: go to IDLE; curr_addr and bytes_left hold their final values.
- Size 0 at start: no L2 access; completion fires on the first RUN cycle.
- cfg_rx_clr_i:
  - flushes the FIFO, clears pending and forces IDLE;
  - if l2_req_o is high without grant, clr is deferred until the gnt cycle, and that write completes.
- Simultaneous cfg_rx_clr_i and cfg_rx_en_i: clr wins and en is ignored.
- Simultaneous FIFO push and pop when full: not allowed, since ready is low while full.
- Simultaneous push and pop when empty: the push is stored and the head is valid next cycle.
- Reset mid-transfer: immediate return to reset values; any in-flight req is dropped.

Decomposition:
- Package tracer_rx_pkg:
  - datasize encoding constants (DS_BYTE, DS_HALF);
  - FSM state enum (IDLE, RUN);
  - FIFO entry struct {datasize, data}.
- Sub-module tracer_rx_fifo: synchronous FIFO, FIFO_DEPTH entries, push/pop/flush, full/empty flags.

Test Plan:
- Halfword transfer: start=0x100, size=8, four halfword beats 0x1111..0x4444, gnt always 1.
  - Writes go to 0x100/be 0011, 0x102/be 1100, 0x104/be 0011, 0x106/be 1100.
  - end_of_transfer_o pulses once; FSM ends in IDLE with curr_addr=0x108, bytes_left=0.
- Byte transfer with back-pressure: start=0x3, size=3, byte beats, gnt low for 3 cycles on the first request.
  - Request outputs stay stable while gnt is low; writes go to 0x3/be 1000, 0x4/be 0001, 0x5/be 0010.
- FIFO full: start=0x0, size=64, valid held high, gnt held low.
  - data_rx_ready_o drops after FIFO_DEPTH accepted beats (4 with the default); no beat is lost once gnt resumes.
- Continuous and pending: continuous=1, size=2, one halfword beat; then an en pulse during RUN with continuous=0.
  - Continuous: reload to startaddr, stay in RUN.
  - Pending: cfg_rx_pending_o=1 until the current transfer completes, then the new start is loaded and pending clears.
- Clear during pending grant: clr pulse while l2_req_o=1 and gnt=0, then gnt=1.
  - The write completes; the following cycle shows IDLE, empty FIFO and pending=0.
- Edge cases:
  - size=0 start: end_of_transfer_o pulses with no L2 access.
  - Halfword beat with bytes_left=1 at address 0x10: be=0001, bytes_left goes to 0.
  - clr and en in the same cycle: the channel stays in IDLE.
